lbuf_rmw_ctl: RTL
=================

# lbuf_rmw_ctl

Line-buffer read-modify-write controller for the object-processor pixel write path. It arbitrates two pixel-write requesters onto the single line-buffer RAM port. Plain writes pass straight through. Additive writes are sequenced as read, saturating add, write-back. The saturating add works per CRY field: cyan nibble, red nibble, Y byte.

## Interface
Parameters:
- AW, 9, line-buffer address width

Ports:
- sys_clk  in  1  system clock; all state on rising edge
- resetl  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a pixel
- req0_ready  out  1  requester 0 accepted this cycle when valid&ready
- req0_addr  in  AW  pixel address
- req0_data  in  16  CRY pixel / signed delta
- req0_add  in  1  1 = additive RMW, 0 = plain write
- req1_valid, req1_ready, req1_addr, req1_data, req1_add  same as requester 0
- ram_addr  out  AW  RAM address, registered
- ram_rd  out  1  RAM read strobe; ram_rdata valid the following cycle
- ram_wr  out  1  RAM write strobe
- ram_wdata  out  16  RAM write data
- ram_rdata  in  16  RAM read data
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, READ, WAIT, WRITE.
- IDLE:
  - Arbitrate. One valid request: grant it.
  - Both valid: grant the requester not granted last (round-robin pointer; pointer = 0 after reset, so requester 0 wins the first tie).
  - reqN_ready = (state==IDLE) & grantN. It is combinational and at most one is high.
  - On accept: latch addr, data and add. Set pointer to the winner.
  - Next state is READ if add=1, else WRITE.
- READ: ram_rd=1, ram_addr=latched addr. Go to WAIT.
- WAIT:
  - Capture ram_rdata as old pixel A. Delta is D = latched data.
  - Compute sum S combinationally. Go to WRITE.
- WRITE:
  - ram_wr=1, ram_addr=latched addr.
  - ram_wdata = S for an add request, latched data otherwise.
  - Go to IDLE.
- Sum S is computed per field, with no carry between fields:
  - Cyan = A[15:12] ⊕ D[15:12].
  - Red = A[11:8] ⊕ D[11:8].
  - Y = A[7:0] ⊕ D[7:0].
- Field rule, n-bit, A unsigned, D two's-complement:
  - (co,s) = A + D, computed n+1 bits wide.
  - If co != D[n-1], the field saturates to all co (all ones on overflow, all zeros on underflow).
  - Otherwise the field is s.
- Reset (resetl low, any time, including mid-RMW):
  - State goes to IDLE immediately. The pointer clears to 0.
  - ram_rd, ram_wr, busy go to 0. ram_addr and ram_wdata go to 0.
  - A pending read-modify-write is dropped with no write issued.
  - Requesters must re-present after reset.
- ram_rd and ram_wr are never high together.

## Timing
- Reset values of all outputs:
  - ram_rd=0, ram_wr=0, ram_addr=0, ram_wdata=0, busy=0.
  - req0_ready and req1_ready = 0 while resetl low, then follow their combinational valid-based rule.
- Plain write accepted at cycle T: ram_wr high in T+1; IDLE in T+2. Throughput is 1 pixel per 2 cycles.
- Add write accepted at T:
  - ram_rd high in T+1.
  - ram_rdata sampled in T+2.
  - ram_wr with S in T+3.
  - IDLE (next accept possible) in T+4.
- Requests seen while not in IDLE are held off with ready=0 and need no special handling.
- Back-to-back adds to the same address read the value already written, because operations are fully serialized.
- A requester dropping valid in the same cycle its grant would occur is simply not accepted. It leaves no state change and does not move the pointer.

## Test plan
- Plain write: req0 addr=0x005, data=0x1234, add=0 → ram_wr in T+1 with addr 0x005, wdata 0x1234; busy for 1 cycle; no ram_rd.
- Add without saturation: RAM[0x010]=0x5480, req1 add, data=0xF120 → ram_rd T+1, ram_wr T+3 with wdata 0x45A0 (5+(-1)=4, 4+1=5, 0x80+0x20=0xA0).
- Saturation at both ends: RAM[0x020]=0xE27F, add data=0x3C01 → 0xF080.
  - Cyan E+3 → F (overflow).
  - Red 2+(-4) → 0 (underflow).
  - Y 0x7F+0x01 → 0x80.
- Y overflow and underflow:
  - RAM=0x00F0, delta=0x0020 → 0x00FF.
  - RAM=0x0010, delta=0x00E0 → 0x0000.
- Round-robin: both requesters valid continuously with plain writes → grants alternate 0,1,0,1 starting with 0 after reset; never both ready.
- Reset mid-RMW: assert resetl low during WAIT → ram_wr never pulses for that request; after release, outputs are 0, busy=0, and the next tie is granted to requester 0.

Source files
------------

// File: rtl/lbuf_rmw_ctl_if.sv
// Line-buffer RMW controller bundle: two pixel
// requesters plus the single-port line-buffer RAM.
interface lbuf_rmw_ctl_if #(
  parameter int AW = 9
);
  logic          req0_valid;
  logic          req0_ready;
  logic [AW-1:0] req0_addr;
  logic [15:0]   req0_data;
  logic          req0_add;
  logic          req1_valid;
  logic          req1_ready;
  logic [AW-1:0] req1_addr;
  logic [15:0]   req1_data;
  logic          req1_add;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic          ram_wr;
  logic [15:0]   ram_wdata;
  logic [15:0]   ram_rdata;
  logic          busy;

  modport master (
    output req0_valid, req0_addr, req0_data, req0_add,
    output req1_valid, req1_addr, req1_data, req1_add,
    output ram_rdata,
    input  req0_ready, req1_ready,
    input  ram_addr, ram_rd, ram_wr, ram_wdata, busy
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req0_add,
    input  req1_valid, req1_addr, req1_data, req1_add,
    input  ram_rdata,
    output req0_ready, req1_ready,
    output ram_addr, ram_rd, ram_wr, ram_wdata, busy
  );
endinterface

// File: rtl/lbuf_rmw_ctl.sv
// Line-buffer write arbiter with per-field saturating
// CRY read-modify-write for additive pixels.
module lbuf_rmw_ctl #(
  parameter int AW = 9
) (
  input  logic         sys_clk,
  input  logic         resetl,
  lbuf_rmw_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, READ, WAIT, WRITE
  } state_t;

  state_t        r_state;
  logic          r_ptr;
  logic          r_seen;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_data;
  logic          r_rd;
  logic          r_wr;
  logic [15:0]   r_wdata;
  logic          r_busy;

  logic          w_v0;
  logic          w_v1;
  logic          w_pick1;
  logic          w_idle;
  logic          w_acc;
  logic [AW-1:0] w_addr;
  logic [15:0]   w_data;
  logic          w_add;
  logic [15:0]   w_sum;

  function automatic logic [3:0] sat4(
    input logic [3:0] a,
    input logic [3:0] d
  );
    logic [4:0] t;
    t = {1'b0, a} + {1'b0, d};
    return (t[4] != d[3]) ? {4{t[4]}} : t[3:0];
  endfunction

  function automatic logic [7:0] sat8(
    input logic [7:0] a,
    input logic [7:0] d
  );
    logic [8:0] t;
    t = {1'b0, a} + {1'b0, d};
    return (t[8] != d[7]) ? {8{t[8]}} : t[7:0];
  endfunction

  assign w_v0   = bus.req0_valid;
  assign w_v1   = bus.req1_valid;
  assign w_idle = (r_state == IDLE);
  assign w_acc  = w_idle & (w_v0 | w_v1);

  // On a tie, requester 1 wins only if requester 0 won last
  assign w_pick1 = (w_v0 & w_v1) ? (r_seen & ~r_ptr) : w_v1;

  assign bus.req0_ready = resetl & w_idle & w_v0 & ~w_pick1;
  assign bus.req1_ready = resetl & w_idle & w_v1 & w_pick1;

  assign w_addr = w_pick1 ? bus.req1_addr : bus.req0_addr;
  assign w_data = w_pick1 ? bus.req1_data : bus.req0_data;
  assign w_add  = w_pick1 ? bus.req1_add  : bus.req0_add;

  assign w_sum = {
    sat4(bus.ram_rdata[15:12], r_data[15:12]),
    sat4(bus.ram_rdata[11:8],  r_data[11:8]),
    sat8(bus.ram_rdata[7:0],   r_data[7:0])
  };

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_seen  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_addr <= w_addr;
            r_data <= w_data;
            r_ptr  <= w_pick1;
            r_seen <= 1'b1;
            r_busy <= 1'b1;
            if (w_add) begin
              r_rd    <= 1'b1;
              r_state <= READ;
            end else begin
              r_wr    <= 1'b1;
              r_wdata <= w_data;
              r_state <= WRITE;
            end
          end
        end
        READ: begin
          r_rd    <= 1'b0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_wr    <= 1'b1;
          r_wdata <= w_sum;
          r_state <= WRITE;
        end
        WRITE: begin
          r_wr    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ram_addr  = r_addr;
  assign bus.ram_rd    = r_rd;
  assign bus.ram_wr    = r_wr;
  assign bus.ram_wdata = r_wdata;
  assign bus.busy      = r_busy;

endmodule
